// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the data-cache miss controller.
// The field split assumes a 32-bit byte address, 16 one-word lines and a 26-bit tag.
package dcache_pkg;

    localparam int DC_ADDR_W = 32;
    localparam int DC_DATA_W = 32;
    localparam int DC_IDX_W  = 4;
    localparam int DC_OFF_W  = 2;
    localparam int DC_TAG_W  = DC_ADDR_W - DC_IDX_W - DC_OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_FILL,
        S_WRMEM,
        S_RESP
    } state_e;

    function automatic logic [DC_TAG_W-1:0] get_tag(input logic [DC_ADDR_W-1:0] addr);
        return DC_TAG_W'(addr >> (DC_IDX_W + DC_OFF_W));
    endfunction

    function automatic logic [DC_IDX_W-1:0] get_idx(input logic [DC_ADDR_W-1:0] addr);
        return DC_IDX_W'(addr >> DC_OFF_W);
    endfunction

endpackage

// File: rtl/dcache_miss_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iInc,
    input  logic         iClear,
    output logic [W-1:0] oCount
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iClear) begin
            cnt_d = '0;
        end else if (iInc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCount = cnt_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache controller: load hits from the array, refill on load misses,
// write-through / write-allocate stores, and saturating hit/miss counters.
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DC_ADDR_W,
    parameter int DATA_W = DC_DATA_W,
    parameter int IDX_W  = DC_IDX_W,
    parameter int TAG_W  = DC_TAG_W,
    parameter int CNT_W  = 16
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReqValid,
    input  logic              iReqWrite,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [DATA_W-1:0] iReqWData,
    output logic              oStall,
    output logic              oRespValid,
    output logic [DATA_W-1:0] oRespData,
    output logic              oLookupEn,
    output logic              oLookupWrite,
    output logic [TAG_W-1:0]  oLookupTag,
    input  logic              iHit,
    output logic [IDX_W-1:0]  oCacheIdx,
    input  logic [DATA_W-1:0] iCacheData,
    output logic              oCacheWe,
    output logic [TAG_W-1:0]  oCacheTag,
    output logic [DATA_W-1:0] oCacheData,
    output logic              oMemReq,
    output logic              oMemWrite,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [CNT_W-1:0]  oHitCnt,
    output logic [CNT_W-1:0]  oMissCnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              cache_we_q, cache_we_d;
    logic [TAG_W-1:0]  cache_tag_q, cache_tag_d;
    logic [DATA_W-1:0] cache_data_q, cache_data_d;
    logic              hit_inc, miss_inc;

    // ack_q marks the cycle after iMemAck: the request is dropped and the array
    // write pulses, so the response lands two cycles after the ack.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        ack_d        = ack_q;
        resp_data_d  = resp_data_q;
        cache_we_d   = 1'b0;
        cache_tag_d  = cache_tag_q;
        cache_data_d = cache_data_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iReqValid) begin
                    addr_d  = iReqAddr;
                    wdata_d = iReqWData;
                    write_d = iReqWrite;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (write_q) begin
                    cache_we_d   = 1'b1;
                    cache_tag_d  = get_tag(addr_q);
                    cache_data_d = wdata_q;
                    state_d      = S_WRMEM;
                end else if (iHit) begin
                    resp_data_d = iCacheData;
                    hit_inc     = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (ack_q) begin
                    ack_d   = 1'b0;
                    state_d = S_RESP;
                end else if (iMemAck) begin
                    ack_d        = 1'b1;
                    cache_we_d   = 1'b1;
                    cache_tag_d  = get_tag(addr_q);
                    cache_data_d = iMemRData;
                    resp_data_d  = iMemRData;
                end
            end
            S_WRMEM: begin
                if (ack_q) begin
                    ack_d   = 1'b0;
                    state_d = S_RESP;
                end else if (iMemAck) begin
                    ack_d = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            ack_q        <= 1'b0;
            resp_data_q  <= '0;
            cache_we_q   <= 1'b0;
            cache_tag_q  <= '0;
            cache_data_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            ack_q        <= ack_d;
            resp_data_q  <= resp_data_d;
            cache_we_q   <= cache_we_d;
            cache_tag_q  <= cache_tag_d;
            cache_data_q <= cache_data_d;
        end
    end

    assign oStall       = ((state_q == S_IDLE) && iReqValid) ||
                          ((state_q != S_IDLE) && (state_q != S_RESP));
    assign oRespValid   = (state_q == S_RESP);
    assign oRespData    = resp_data_q;
    assign oLookupEn    = (state_q == S_LOOKUP);
    assign oLookupWrite = write_q;
    assign oLookupTag   = get_tag(addr_q);
    assign oCacheIdx    = get_idx(addr_q);
    assign oCacheWe     = cache_we_q;
    assign oCacheTag    = cache_tag_q;
    assign oCacheData   = cache_data_q;
    assign oMemReq      = ((state_q == S_FILL) || (state_q == S_WRMEM)) && !ack_q;
    assign oMemWrite    = (state_q == S_WRMEM);
    assign oMemAddr     = addr_q & ~ADDR_W'(3);
    assign oMemWData    = wdata_q;

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .iClk   (iClk),
        .iRst   (iRst),
        .iInc   (hit_inc),
        .iClear (1'b0),
        .oCount (oHitCnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .iClk   (iClk),
        .iRst   (iRst),
        .iInc   (miss_inc),
        .iClear (1'b0),
        .oCount (oMissCnt)
    );

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed self-checking bench for dcache_miss_ctrl (counters built 4 bits wide).
module tb_dcache_miss_ctrl;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iReqValid = 1'b0;
    logic        iReqWrite = 1'b0;
    logic [31:0] iReqAddr = '0;
    logic [31:0] iReqWData = '0;
    logic        oStall, oRespValid, oLookupEn, oLookupWrite;
    logic [31:0] oRespData;
    logic [25:0] oLookupTag;
    logic        iHit = 1'b0;
    logic [3:0]  oCacheIdx;
    logic [31:0] iCacheData = '0;
    logic        oCacheWe;
    logic [25:0] oCacheTag;
    logic [31:0] oCacheData;
    logic        oMemReq, oMemWrite;
    logic [31:0] oMemAddr, oMemWData;
    logic        iMemAck = 1'b0;
    logic [31:0] iMemRData = '0;
    logic [3:0]  oHitCnt, oMissCnt;

    int checks = 0;
    int errors = 0;

    int          r_lat, r_req_cyc, r_we_cnt;
    logic        r_memwr, r_lk_write;
    logic [31:0] r_lk_tag, r_we_idx, r_we_tag, r_we_data, r_mem_addr, r_mem_wdata, r_resp;

    dcache_miss_ctrl #(.CNT_W(4)) dut (
        .iClk(iClk), .iRst(iRst),
        .iReqValid(iReqValid), .iReqWrite(iReqWrite), .iReqAddr(iReqAddr), .iReqWData(iReqWData),
        .oStall(oStall), .oRespValid(oRespValid), .oRespData(oRespData),
        .oLookupEn(oLookupEn), .oLookupWrite(oLookupWrite), .oLookupTag(oLookupTag),
        .iHit(iHit), .oCacheIdx(oCacheIdx), .iCacheData(iCacheData),
        .oCacheWe(oCacheWe), .oCacheTag(oCacheTag), .oCacheData(oCacheData),
        .oMemReq(oMemReq), .oMemWrite(oMemWrite), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
        .iMemAck(iMemAck), .iMemRData(iMemRData),
        .oHitCnt(oHitCnt), .oMissCnt(oMissCnt)
    );

    always #5 iClk = ~iClk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Issue one request at an IDLE cycle, play memory (ack on the ack_dly-th
    // request cycle), record what the DUT did, and return one cycle after RESP.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic hit, input int ack_dly, input logic [31:0] rdata,
                           input logic [31:0] cdata);
        r_lat = -1; r_req_cyc = 0; r_we_cnt = 0;
        r_memwr = 1'b0; r_lk_write = 1'b0;
        r_lk_tag = '0; r_we_idx = '0; r_we_tag = '0; r_we_data = '0;
        r_mem_addr = '0; r_mem_wdata = '0; r_resp = '0;
        iReqValid = 1'b1; iReqWrite = wr; iReqAddr = addr; iReqWData = wdata;
        iHit = hit; iCacheData = cdata;
        for (int c = 1; c <= 40 && r_lat < 0; c++) begin
            tick();
            iMemAck = 1'b0;
            if (oLookupEn) begin
                r_lk_write = oLookupWrite;
                r_lk_tag   = 32'(oLookupTag);
            end
            if (oCacheWe) begin
                r_we_cnt++;
                r_we_idx  = 32'(oCacheIdx);
                r_we_tag  = 32'(oCacheTag);
                r_we_data = oCacheData;
            end
            if (oMemReq) begin
                r_req_cyc++;
                r_memwr     = oMemWrite;
                r_mem_addr  = oMemAddr;
                r_mem_wdata = oMemWData;
                if (r_req_cyc == ack_dly) begin
                    iMemAck   = 1'b1;
                    iMemRData = rdata;
                end
            end
            if (oRespValid) begin
                r_lat  = c;
                r_resp = oRespData;
            end
        end
        iReqValid = 1'b0;
        iMemAck   = 1'b0;
        tick();
    endtask

    initial begin
        int we_seen, rv_seen, req_seen, lk_seen;
        #22 iRst = 1'b0;
        tick();

        check_eq("rst_stall", 32'(oStall), 0);
        check_eq("rst_memreq", 32'(oMemReq), 0);
        check_eq("rst_respvalid", 32'(oRespValid), 0);
        check_eq("rst_cachewe", 32'(oCacheWe), 0);
        check_eq("rst_respdata", oRespData, 0);
        check_eq("rst_hitcnt", 32'(oHitCnt), 0);
        check_eq("rst_misscnt", 32'(oMissCnt), 0);

        // Load miss, ack on the third request cycle
        run_txn(1'b0, 32'h0000_0040, 32'h0, 1'b0, 3, 32'hDEAD_BEEF, 32'h0);
        check_eq("miss_lat", 32'(r_lat), 7);
        check_eq("miss_lk_write", 32'(r_lk_write), 0);
        check_eq("miss_lk_tag", r_lk_tag, 32'h1);
        check_eq("miss_req_cycles", 32'(r_req_cyc), 3);
        check_eq("miss_memwrite", 32'(r_memwr), 0);
        check_eq("miss_memaddr", r_mem_addr, 32'h40);
        check_eq("miss_we_count", 32'(r_we_cnt), 1);
        check_eq("miss_we_idx", r_we_idx, 0);
        check_eq("miss_we_tag", r_we_tag, 32'h1);
        check_eq("miss_we_data", r_we_data, 32'hDEAD_BEEF);
        check_eq("miss_resp", r_resp, 32'hDEAD_BEEF);
        check_eq("miss_misscnt", 32'(oMissCnt), 1);
        check_eq("miss_hitcnt", 32'(oHitCnt), 0);

        // Load hit
        run_txn(1'b0, 32'h0000_0040, 32'h0, 1'b1, 0, 32'h0, 32'h1234_5678);
        check_eq("hit_lat", 32'(r_lat), 3);
        check_eq("hit_req_cycles", 32'(r_req_cyc), 0);
        check_eq("hit_we_count", 32'(r_we_cnt), 0);
        check_eq("hit_resp", r_resp, 32'h1234_5678);
        check_eq("hit_hitcnt", 32'(oHitCnt), 1);
        check_eq("hit_misscnt", 32'(oMissCnt), 1);

        // Store; iHit=1 must be ignored
        run_txn(1'b1, 32'h0000_0084, 32'hA5A5_A5A5, 1'b1, 3, 32'h0, 32'h0);
        check_eq("st_lk_write", 32'(r_lk_write), 1);
        check_eq("st_lk_tag", r_lk_tag, 32'h2);
        check_eq("st_we_count", 32'(r_we_cnt), 1);
        check_eq("st_we_idx", r_we_idx, 32'h1);
        check_eq("st_we_tag", r_we_tag, 32'h2);
        check_eq("st_we_data", r_we_data, 32'hA5A5_A5A5);
        check_eq("st_req_cycles", 32'(r_req_cyc), 3);
        check_eq("st_memwrite", 32'(r_memwr), 1);
        check_eq("st_memaddr", r_mem_addr, 32'h84);
        check_eq("st_memwdata", r_mem_wdata, 32'hA5A5_A5A5);
        check_eq("st_lat", 32'(r_lat), 7);
        check_eq("st_hitcnt", 32'(oHitCnt), 1);
        check_eq("st_misscnt", 32'(oMissCnt), 1);

        // Stray ack while idle
        iMemAck = 1'b1; iMemRData = 32'hFFFF_FFFF;
        tick();
        iMemAck = 1'b0;
        tick();
        check_eq("stray_memreq", 32'(oMemReq), 0);
        check_eq("stray_cachewe", 32'(oCacheWe), 0);
        check_eq("stray_respvalid", 32'(oRespValid), 0);
        check_eq("stray_stall", 32'(oStall), 0);
        check_eq("stray_lookup", 32'(oLookupEn), 0);
        check_eq("stray_hitcnt", 32'(oHitCnt), 1);
        check_eq("stray_misscnt", 32'(oMissCnt), 1);

        // Reset in the middle of a refill
        iReqValid = 1'b1; iReqWrite = 1'b0; iReqAddr = 32'h0000_0200; iHit = 1'b0;
        tick(); tick(); tick();
        check_eq("fill_memreq", 32'(oMemReq), 1);
        #2;
        iReqValid = 1'b0;
        iRst = 1'b1;
        #1;
        check_eq("arst_memreq", 32'(oMemReq), 0);
        check_eq("arst_stall", 32'(oStall), 0);
        check_eq("arst_misscnt", 32'(oMissCnt), 0);
        check_eq("arst_hitcnt", 32'(oHitCnt), 0);
        @(negedge iClk);
        iRst = 1'b0;
        tick();
        iMemAck = 1'b1; iMemRData = 32'h5555_AAAA;
        tick();
        iMemAck = 1'b0;
        we_seen = 0; rv_seen = 0; req_seen = 0; lk_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (oCacheWe) we_seen++;
            if (oRespValid) rv_seen++;
            if (oMemReq) req_seen++;
            if (oLookupEn) lk_seen++;
            tick();
        end
        check_eq("post_rst_we", 32'(we_seen), 0);
        check_eq("post_rst_respvalid", 32'(rv_seen), 0);
        check_eq("post_rst_memreq", 32'(req_seen), 0);
        check_eq("post_rst_lookup", 32'(lk_seen), 0);

        // 17 back-to-back load hits saturate the 4-bit hit counter
        for (int i = 0; i < 17; i++) begin
            run_txn(1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, 1'b1, 0, 32'h0, 32'hC0DE_0000 + 32'(i));
            check_eq("sat_lat", 32'(r_lat), 3);
            if (i == 13) check_eq("sat_cnt14", 32'(oHitCnt), 14);
        end
        check_eq("sat_resp_last", r_resp, 32'hC0DE_0010);
        check_eq("sat_hitcnt", 32'(oHitCnt), 32'hF);
        check_eq("sat_misscnt", 32'(oMissCnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
Data-cache controller FSM that sits directly downstream of the registered tag-compare (hit) stage. It accepts CPU load/store requests, drives the tag-compare stage, and consumes its one-cycle-late hit flag. It serves load hits from the cache array, refills on load misses from main memory, and handles stores as write-through with write-allocate. It also keeps saturating hit/miss counters.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width (one word per line)
IDX_W, 4, line index bits (16 lines)
TAG_W, 26, tag width = ADDR_W-IDX_W-2
CNT_W, 16, width of hit/miss counters

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  reset, asynchronous, active-high
iReqValid  in  1  CPU request; held stable until oRespValid
iReqWrite  in  1  1 = store, 0 = load
iReqAddr  in  ADDR_W  byte address, word aligned
iReqWData  in  DATA_W  store data
oStall  out  1  CPU pipeline stall
oRespValid  out  1  one-cycle completion pulse
oRespData  out  DATA_W  load data, valid with oRespValid
oLookupEn  out  1  tag-compare stage enable; write flag passed through as oLookupWrite
oLookupWrite  out  1  store marker to hit stage (forces miss)
oLookupTag  out  TAG_W  target tag for compare
iHit  in  1  registered hit, valid the cycle after oLookupEn
oCacheIdx  out  IDX_W  array index (always the latched address index)
iCacheData  in  DATA_W  array read data at oCacheIdx (combinational)
oCacheWe  out  1  array write: writes V=1, tag, data
oCacheTag  out  TAG_W  tag to write
oCacheData  out  DATA_W  data to write
oMemReq  out  1  memory request, held until iMemAck
oMemWrite  out  1  1 = memory write
oMemAddr  out  ADDR_W  memory word address
oMemWData  out  DATA_W  memory write data
iMemAck  in  1  memory completion, one-cycle pulse
iMemRData  in  DATA_W  read data, valid with iMemAck
oHitCnt  out  CNT_W  load-hit counter
oMissCnt  out  CNT_W  load-miss counter

Behaviour:
- Field split: tag = addr[31:6], idx = addr[5:2], addr[1:0] ignored.
- Reset (asynchronous, immediate): state IDLE; all registered outputs 0; latched request cleared; counters 0. An outstanding memory request is abandoned. The controller never clears array valid bits; the array owns them.
- States: IDLE, LOOKUP, CHECK, FILL, WRMEM, RESP.
- IDLE: when iReqValid=1, latch addr/wdata/write and go to LOOKUP. iReqValid is sampled only in IDLE.
- LOOKUP: oLookupEn=1, with oLookupTag and oLookupWrite from the latch. Go to CHECK.
- CHECK: sample iHit.
  - Store: go to WRMEM. iHit is ignored and counters are unchanged.
  - Load, iHit=1: oRespData <= iCacheData, oHitCnt++, go to RESP.
  - Load, iHit=0: oMissCnt++, go to FILL.
- FILL: oMemReq=1, oMemWrite=0, oMemAddr = {addr[31:2],2'b00}.
  - On iMemAck: oCacheWe=1 for exactly the ack cycle (registered, so it is a one-cycle pulse the cycle after ack, with tag/data = latched tag, iMemRData); oRespData <= iMemRData; go to RESP.
- WRMEM: oMemReq=1, oMemWrite=1, oMemWData = latched wdata. oCacheWe pulses once on entry (tag, wdata), which implements write-allocate. On iMemAck go to RESP.
- RESP: oRespValid=1 for one cycle, oMemReq=0, then go to IDLE.
- Latencies (accept cycle = 0):
  - Load hit: oRespValid at cycle 3.
  - Miss/store: oRespValid 2 cycles after the iMemAck cycle.
- oStall (combinational) = (IDLE & iReqValid) | state not in {IDLE, RESP}.
- oMemReq stays stable until ack. iMemAck outside FILL/WRMEM is ignored.
- Counters saturate at all-ones and never wrap.
- A new request may be presented the cycle after RESP; back-to-back throughput is one request per 4 cycles on hits.

Decomposition:
- Package dcache_pkg holds:
  - state enum
  - IDX_W/TAG_W/offset constants
  - functions get_tag(addr) and get_idx(addr)
- One sub-module, sat_counter (param W; inc, clear, async iRst), instantiated twice.

Test Plan:
1. Load miss: reset, load 0x0000_0040, iHit=0, ack after 3 cycles with 0xDEADBEEF. Required: oMemReq/oMemAddr=0x40; oCacheWe pulse with idx 0, tag 0x1, data 0xDEADBEEF; oRespValid with oRespData 0xDEADBEEF; oMissCnt=1.
2. Load hit: load 0x0000_0040, iHit=1, iCacheData=0x12345678. Required: oRespValid exactly 3 cycles after accept; oMemReq never high; oHitCnt=1.
3. Store 0x0000_0084 with data 0xA5A5A5A5. Required: oLookupWrite=1; oCacheWe with idx 1, tag 0x2; oMemReq=1/oMemWrite=1 held until ack; oRespValid; counters unchanged.
4. Assert iRst mid-FILL while oMemReq=1. Required: oMemReq/oStall drop without waiting for a clock edge; state IDLE; a later iMemAck causes no oCacheWe and no oRespValid.
5. Stray iMemAck in IDLE with iReqValid=0. Required: no output changes.
6. With CNT_W=4, run 17 load hits. Required: oHitCnt=0xF, oMissCnt=0.
